// File: rtl/sha1_pad.sv
// rtl/sha1_pad.sv - SHA-1 message padder: 32-bit word stream in, 512-bit padded blocks out
module sha1_pad #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_data,
    input  logic           in_last,
    input  logic [2:0]     in_nbytes,
    output logic           blk_valid,
    input  logic           blk_ready,
    output logic [511:0]   blk_data,
    output logic           blk_last
);

    typedef enum logic [1:0] {FILL, OUT, FIN1, FIN2} state_t;

    state_t         state_q, state_d;
    logic [3:0]     wcnt_q;
    logic [63:0]    len_q;
    logic [511:0]   mem_q;
    logic           pending_q;
    logic [6:0]     b_q;
    logic           in_ready_q;
    logic           blk_valid_q;

    logic           in_fire;
    logic           blk_fire;
    logic           final_done;
    logic [2:0]     nb;
    logic [N-1:0]   masked_word;
    logic [8:0]     wbase;
    logic [511:0]   blk_comb;
    logic           last_comb;

    assign in_fire  = in_valid & in_ready_q;
    assign blk_fire = blk_valid_q & blk_ready;
    assign nb       = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    assign wbase    = 9'd511 - {wcnt_q, 5'd0};

    assign final_done = blk_fire &&
                        ((state_q == FIN1 && b_q < 7'd56) || state_q == FIN2);

    // Bytes at and beyond in_nbytes are cleared so the tail of the last word never leaks.
    always_comb begin
        masked_word = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < int'(nb))
                masked_word[31-8*j -: 8] = in_data[31-8*j -: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (in_fire) begin
                    if (in_last)
                        state_d = FIN1;
                    else if (wcnt_q == 4'd15)
                        state_d = OUT;
                end
            end
            OUT:  if (blk_fire) state_d = FILL;
            FIN1: if (blk_fire) state_d = (b_q >= 7'd56) ? FIN2 : FILL;
            FIN2: if (blk_fire) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wcnt_q      <= '0;
            len_q       <= '0;
            mem_q       <= '0;
            pending_q   <= 1'b0;
            b_q         <= '0;
            in_ready_q  <= 1'b0;
            blk_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == FILL);
            blk_valid_q <= (state_d != FILL);
            if (in_fire) begin
                if (in_last) begin
                    mem_q[wbase -: 32] <= masked_word;
                    len_q     <= len_q + {58'd0, nb, 3'd0};
                    b_q       <= {1'b0, wcnt_q, 2'b00} + {4'd0, nb};
                    pending_q <= (wcnt_q == 4'd15) && (nb == 3'd4);
                end else begin
                    mem_q[wbase -: 32] <= in_data;
                    len_q  <= len_q + 64'd32;
                    wcnt_q <= wcnt_q + 4'd1;
                end
            end
            if (blk_fire && state_q == OUT)
                wcnt_q <= '0;
            if (final_done) begin
                len_q     <= '0;
                wcnt_q    <= '0;
                pending_q <= 1'b0;
            end
        end
    end

    // Block image is derived from registered state only, so it holds while backpressured.
    always_comb begin
        blk_comb  = '0;
        last_comb = 1'b0;
        case (state_q)
            OUT: blk_comb = mem_q;
            FIN1: begin
                for (int i = 0; i < 64; i++) begin
                    if (i < int'(b_q))
                        blk_comb[511-8*i -: 8] = mem_q[511-8*i -: 8];
                    else if (i == int'(b_q))
                        blk_comb[511-8*i -: 8] = 8'h80;
                end
                if (b_q <= 7'd55) begin
                    blk_comb[63:0] = len_q;
                    last_comb      = 1'b1;
                end
            end
            FIN2: begin
                if (pending_q)
                    blk_comb[511:504] = 8'h80;
                blk_comb[63:0] = len_q;
                last_comb      = 1'b1;
            end
            default: ;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign blk_valid = blk_valid_q;
    assign blk_data  = blk_valid_q ? blk_comb : '0;
    assign blk_last  = blk_valid_q & last_comb;

endmodule

// File: tb/tb_sha1_pad.sv
// tb/tb_sha1_pad.sv - directed self-checking bench for sha1_pad
module tb_sha1_pad;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_nbytes;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;

    int n_total = 0;
    int n_pass  = 0;

    logic [511:0] exp_abc, exp_empty, exp56_1, exp56_2, exp64_1, exp64_2;

    sha1_pad #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic [2:0] nb);
        int n;
        bit ok;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = l;
        in_nbytes = nb;
        ok = 1'b0;
        for (n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [511:0] exp_d, input logic exp_l);
        int n;
        bit ok;
        blk_ready = 1'b1;
        ok = 1'b0;
        for (n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (blk_valid) ok = 1'b1;
        end
        if (!ok) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_data"}, blk_data, exp_d);
            check({tag, "_last"}, {511'd0, blk_last}, {511'd0, exp_l});
        end
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
    endtask

    task automatic send_abc();
        send(32'h61626300, 1'b1, 3'd3);
        recv("abc", exp_abc, 1'b1);
    endtask

    initial begin
        exp_abc   = '0;
        exp_abc[511:480] = 32'h61626380;
        exp_abc[31:0]    = 32'h00000018;
        exp_empty = '0;
        exp_empty[511:480] = 32'h80000000;
        exp56_1 = '0;
        for (int i = 0; i < 14; i++) exp56_1[511-32*i -: 32] = 32'h10000000 + i;
        exp56_1[63:32] = 32'h80000000;
        exp56_2 = '0;
        exp56_2[31:0] = 32'h000001C0;
        exp64_1 = '0;
        for (int i = 0; i < 16; i++) exp64_1[511-32*i -: 32] = 32'h10000000 + i;
        exp64_2 = '0;
        exp64_2[511:480] = 32'h80000000;
        exp64_2[31:0]    = 32'h00000200;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_nbytes = '0; blk_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  {511'd0, in_ready},  0);
        check("rst_blk_valid", {511'd0, blk_valid}, 0);
        check("rst_blk_data",  blk_data, 0);
        check("rst_blk_last",  {511'd0, blk_last},  0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", {511'd0, in_ready}, 1);

        send_abc();

        send(32'h00000000, 1'b1, 3'd0);
        recv("empty", exp_empty, 1'b1);

        for (int i = 0; i < 14; i++) send(32'h10000000 + i, i == 13, 3'd4);
        recv("m56_b1", exp56_1, 1'b0);
        recv("m56_b2", exp56_2, 1'b1);

        // 64-byte message; first block held off for five cycles
        for (int i = 0; i < 16; i++) send(32'h10000000 + i, i == 15, 3'd4);
        for (int n = 0; n < 50 && !blk_valid; n++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_data",     blk_data, exp64_1);
            check("bp_in_ready", {511'd0, in_ready},  0);
            check("bp_valid",    {511'd0, blk_valid}, 1);
        end
        check("bp_last", {511'd0, blk_last}, 0);
        blk_ready = 1'b1;
        @(posedge clk); #1;
        blk_ready = 1'b0;
        check("bp_xfer_valid", {511'd0, blk_valid}, 1);
        check("bp_xfer_block2", blk_data, exp64_2);
        recv("m64_b2", exp64_2, 1'b1);

        // abort a message after 7 words
        for (int i = 0; i < 7; i++) send(32'hDEAD0000 + i, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  {511'd0, in_ready},  0);
        check("mid_rst_blk_valid", {511'd0, blk_valid}, 0);
        check("mid_rst_blk_data",  blk_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_abc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sha1_pad.md
SHA1_PAD -- requirements
Module: sha1_pad

Interface
REQ-001 SHALL have parameter N, default 32: message word width in bits; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data, in_last and in_nbytes are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an input beat.
REQ-006 SHALL have port in_data, input, N bits: message word, big-endian, first byte in bits [31:24].
REQ-007 SHALL have port in_last, input, 1 bit: this beat ends the message.
REQ-008 SHALL have port in_nbytes, input, 3 bits: number of valid bytes (0..4) when in_last=1; ignored otherwise.
REQ-009 SHALL have port blk_valid, output, 1 bit: blk_data holds a complete 512-bit block.
REQ-010 SHALL have port blk_ready, input, 1 bit: the downstream w generator accepts the block.
REQ-011 SHALL have port blk_data, output, 512 bits: the block, word 0 in bits [511:480].
REQ-012 SHALL have port blk_last, output, 1 bit: this is the final padded block of the message.

Function
REQ-013 SHALL transfer an input beat only when in_valid=1 and in_ready=1, and a block only when blk_valid=1 and blk_ready=1.
REQ-014 SHALL use a state machine with states FILL, OUT, FIN1 and FIN2.
REQ-015 SHALL drive in_ready=1 only in FILL and blk_valid=1 only in OUT, FIN1 and FIN2, so input and output transfers never coincide.
REQ-016 SHALL, in FILL, write each accepted word into buffer word index wcnt (0..15), then increment wcnt.
REQ-017 SHALL add 32 to a 64-bit bit-length counter for each non-last beat, and 8*in_nbytes for a last beat; the counter wraps modulo 2^64.
REQ-018 SHALL, when the 16th word is accepted with in_last=0, move to OUT; blk_valid SHALL rise the next cycle with blk_last=0.
REQ-019 SHALL, when OUT is accepted, clear wcnt and return to FILL.
REQ-020 SHALL, on a last beat, zero the bytes at and after in_nbytes in that word, then move to FIN1; b is the count of message bytes in the current block (0..64).
REQ-021 SHALL, in FIN1 with b<=55, present: the message bytes, 0x80 at byte b, zeros, and the bit length big-endian in bytes 56..63, with blk_last=1.
REQ-022 SHALL, in FIN1 with 56<=b<=63, present the message bytes, 0x80 at byte b and zeros, with blk_last=0; after acceptance it SHALL go to FIN2.
REQ-023 SHALL, in FIN1 with b=64, present the message bytes unchanged with blk_last=0; after acceptance it SHALL go to FIN2 with the 0x80 marker still pending.
REQ-024 SHALL, in FIN2, present zeros (0x80 at byte 0 if the marker is pending) plus the length in bytes 56..63, with blk_last=1.
REQ-025 SHALL, after the final block is accepted, clear the length counter, wcnt and the pending flag, and return to FILL.
REQ-026 SHALL hold blk_data and blk_last stable while blk_valid=1 and blk_ready=0.
REQ-027 SHALL treat in_last with in_nbytes=0 as a valid message end; an empty message gives b=0.

Reset
REQ-028 SHALL, while rst_n=0, force state FILL, wcnt=0, length=0, buffer=0, pending=0, in_ready=0, blk_valid=0, blk_data=0 and blk_last=0.
REQ-029 SHALL assert in_ready in the first cycle after rst_n deasserts.
REQ-030 SHALL, on reset mid-message, discard all partial state; the next message SHALL be padded independently.

Verification
REQ-031 SHALL test "abc": one beat 0x61626300, nbytes=3, last -> one block, word0=0x61626380, words1..14=0, word15=0x00000018, blk_last=1.
REQ-032 SHALL test the empty message: last with nbytes=0 -> word0=0x80000000, others 0, word15=0, blk_last=1.
REQ-033 SHALL test a 56-byte message (14 full words, last nbytes=4):
  - block1: word14=0x80000000, word15=0, blk_last=0;
  - block2: all 0 except word15=0x000001C0, blk_last=1.
REQ-034 SHALL test a 64-byte message:
  - block1: data only, blk_last=0;
  - block2: word0=0x80000000, word15=0x00000200, blk_last=1.
REQ-035 SHALL test backpressure: hold blk_ready=0 for 5 cycles during OUT -> blk_data constant and in_ready=0 throughout; the transfer occurs on the first cycle with blk_ready=1.
REQ-036 SHALL test reset mid-fill: pulse rst_n low after 7 words -> outputs zero; a following "abc" message -> same result as REQ-031.
